// File: rtl/game_controller.sv
// Robot maze game sequencer: one-step moves validated by external goal/wall
// region checkers, a tick-driven countdown, and a saturating bump counter.
module game_controller #(
    parameter logic [8:0]  START_X   = 9'd140,
    parameter logic [8:0]  START_Y   = 9'd100,
    parameter logic [8:0]  X_MAX     = 9'd159,
    parameter logic [8:0]  Y_MAX     = 9'd119,
    parameter logic [6:0]  TIME_INIT = 7'd99,
    parameter int unsigned CHECK_LAT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       move_req,
    input  logic [1:0] dir,
    input  logic       tick,
    input  logic [2:0] goal_flag,
    input  logic [2:0] wall_flag,
    output logic [8:0] chk_x,
    output logic [8:0] chk_y,
    output logic [8:0] x_pos,
    output logic [8:0] y_pos,
    output logic       move_ack,
    output logic       bump,
    output logic [7:0] bump_count,
    output logic [6:0] time_left,
    output logic       won,
    output logic       lost
);

    // state  | meaning
    // IDLE   | held at start position, waiting for start
    // READY  | waiting for a move request, loses when time runs out
    // CALC   | latch candidate position and boundary block
    // WAIT   | candidate held stable while region checkers settle
    // DECIDE | resolve the move from boundary/goal/wall, pulse move_ack
    // WIN    | goal reached, frozen until start
    // LOSE   | time expired, frozen until start
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        CALC   = 3'd2,
        WAIT   = 3'd3,
        DECIDE = 3'd4,
        WIN    = 3'd5,
        LOSE   = 3'd6
    } state_e;

    localparam logic [3:0] LAT = 4'(CHECK_LAT);

    state_e     state_q, state_d;
    logic [8:0] x_pos_q, x_pos_d;
    logic [8:0] y_pos_q, y_pos_d;
    logic [8:0] chk_x_q, chk_x_d;
    logic [8:0] chk_y_q, chk_y_d;
    logic       blk_q, blk_d;
    logic [3:0] cnt_q, cnt_d;
    logic       move_ack_q, move_ack_d;
    logic       bump_q, bump_d;
    logic [7:0] bump_cnt_q, bump_cnt_d;
    logic [6:0] time_q, time_d;
    logic       won_q, won_d;
    logic       lost_q, lost_d;

    logic [8:0] cand_x, cand_y;
    logic       cand_blk;
    logic       tick_en;

    // Candidate one step away; steps off the board keep the current position.
    always_comb begin
        cand_x   = x_pos_q;
        cand_y   = y_pos_q;
        cand_blk = 1'b0;
        case (dir)
            2'b00: begin
                if (y_pos_q == 9'd0) cand_blk = 1'b1;
                else                 cand_y   = y_pos_q - 9'd1;
            end
            2'b01: begin
                if (y_pos_q >= Y_MAX) cand_blk = 1'b1;
                else                  cand_y   = y_pos_q + 9'd1;
            end
            2'b10: begin
                if (x_pos_q == 9'd0) cand_blk = 1'b1;
                else                 cand_x   = x_pos_q - 9'd1;
            end
            default: begin
                if (x_pos_q >= X_MAX) cand_blk = 1'b1;
                else                  cand_x   = x_pos_q + 9'd1;
            end
        endcase
    end

    assign tick_en = tick && ((state_q == READY) || (state_q == CALC) ||
                              (state_q == WAIT)  || (state_q == DECIDE));

    always_comb begin
        state_d    = state_q;
        x_pos_d    = x_pos_q;
        y_pos_d    = y_pos_q;
        blk_d      = blk_q;
        cnt_d      = cnt_q;
        move_ack_d = 1'b0;
        bump_d     = 1'b0;
        bump_cnt_d = bump_cnt_q;
        time_d     = time_q;

        if (tick_en && (time_q != 7'd0)) begin
            time_d = time_q - 7'd1;
        end

        case (state_q)
            IDLE: begin
                x_pos_d    = START_X;
                y_pos_d    = START_Y;
                time_d     = TIME_INIT;
                bump_cnt_d = 8'd0;
                if (start) state_d = READY;
            end
            READY: begin
                if (time_q == 7'd0)  state_d = LOSE;
                else if (move_req)   state_d = CALC;
            end
            CALC: begin
                blk_d   = cand_blk;
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = DECIDE;
            end
            DECIDE: begin
                move_ack_d = 1'b1;
                state_d    = READY;
                if (blk_q) begin
                    bump_d = 1'b1;
                end else if (goal_flag == 3'b000) begin
                    x_pos_d = chk_x_q;
                    y_pos_d = chk_y_q;
                    state_d = WIN;
                end else if (wall_flag == 3'b000) begin
                    bump_d = 1'b1;
                end else begin
                    x_pos_d = chk_x_q;
                    y_pos_d = chk_y_q;
                end
            end
            WIN, LOSE: begin
                if (start) begin
                    x_pos_d    = START_X;
                    y_pos_d    = START_Y;
                    time_d     = TIME_INIT;
                    bump_cnt_d = 8'd0;
                    state_d    = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bump_d && (bump_cnt_q != 8'hFF)) begin
            bump_cnt_d = bump_cnt_q + 8'd1;
        end

        // Checkers see the candidate from WAIT through DECIDE, else the position.
        if (state_q == CALC) begin
            chk_x_d = cand_x;
            chk_y_d = cand_y;
        end else if (state_q == WAIT) begin
            chk_x_d = chk_x_q;
            chk_y_d = chk_y_q;
        end else begin
            chk_x_d = x_pos_d;
            chk_y_d = y_pos_d;
        end

        won_d  = (state_d == WIN);
        lost_d = (state_d == LOSE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_pos_q    <= START_X;
            y_pos_q    <= START_Y;
            chk_x_q    <= START_X;
            chk_y_q    <= START_Y;
            blk_q      <= 1'b0;
            cnt_q      <= 4'd0;
            move_ack_q <= 1'b0;
            bump_q     <= 1'b0;
            bump_cnt_q <= 8'd0;
            time_q     <= TIME_INIT;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            chk_x_q    <= chk_x_d;
            chk_y_q    <= chk_y_d;
            blk_q      <= blk_d;
            cnt_q      <= cnt_d;
            move_ack_q <= move_ack_d;
            bump_q     <= bump_d;
            bump_cnt_q <= bump_cnt_d;
            time_q     <= time_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
        end
    end

    assign chk_x      = chk_x_q;
    assign chk_y      = chk_y_q;
    assign x_pos      = x_pos_q;
    assign y_pos      = y_pos_q;
    assign move_ack   = move_ack_q;
    assign bump       = bump_q;
    assign bump_count = bump_cnt_q;
    assign time_left  = time_q;
    assign won        = won_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed + randomized bench for game_controller against a position-level game model.
module tb_game_controller;

    logic       clock = 1'b0;
    logic       reset, start, move_req, tick;
    logic [1:0] dir;
    logic [2:0] goal_flag, wall_flag;
    logic [8:0] chk_x, chk_y, x_pos, y_pos;
    logic       move_ack, bump, won, lost;
    logic [7:0] bump_count;
    logic [6:0] time_left;

    game_controller dut (
        .clock(clock), .reset(reset), .start(start), .move_req(move_req),
        .dir(dir), .tick(tick), .goal_flag(goal_flag), .wall_flag(wall_flag),
        .chk_x(chk_x), .chk_y(chk_y), .x_pos(x_pos), .y_pos(y_pos),
        .move_ack(move_ack), .bump(bump), .bump_count(bump_count),
        .time_left(time_left), .won(won), .lost(lost)
    );

    always #5 clock = ~clock;

    localparam int XMAX = 159;
    localparam int YMAX = 119;

    int checks = 0;
    int errors = 0;

    // Game model: position, remaining time, bump count, end flags.
    int mx, my, mt, mb;
    bit mwon, mlost;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_init();
        mx = 140; my = 100; mt = 99; mb = 0; mwon = 0; mlost = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_x"},    32'(x_pos), 32'(mx));
        check({tag, "_y"},    32'(y_pos), 32'(my));
        check({tag, "_chkx"}, 32'(chk_x), 32'(mx));
        check({tag, "_chky"}, 32'(chk_y), 32'(my));
        check({tag, "_time"}, 32'(time_left), 32'(mt));
        check({tag, "_bcnt"}, 32'(bump_count), 32'(mb));
        check({tag, "_won"},  32'(won), 32'(mwon));
        check({tag, "_lost"}, 32'(lost), 32'(mlost));
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_init();
        check_state("start");
    endtask

    task automatic do_ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
        mt = (mt > n) ? mt - n : 0;
    endtask

    task automatic do_move(input logic [1:0] d, input logic [2:0] g, input logic [2:0] w,
                           input bit tick_dec);
        int cx, cy;
        bit blk, exp_bump;
        cx = mx; cy = my; blk = 0;
        case (d)
            2'b00: if (my == 0)    blk = 1; else cy = my - 1;
            2'b01: if (my >= YMAX) blk = 1; else cy = my + 1;
            2'b10: if (mx == 0)    blk = 1; else cx = mx - 1;
            default: if (mx >= XMAX) blk = 1; else cx = mx + 1;
        endcase

        dir = d; goal_flag = g; wall_flag = w; move_req = 1'b1;
        step();
        check("calc_chkx", 32'(chk_x), 32'(mx));
        check("calc_ack", 32'(move_ack), 0);
        step();
        dir = 2'($urandom);
        check("wait_chkx", 32'(chk_x), 32'(cx));
        check("wait_chky", 32'(chk_y), 32'(cy));
        step();
        check("wait2_ack", 32'(move_ack), 0);
        check("wait2_chkx", 32'(chk_x), 32'(cx));
        step();
        check("decide_ack", 32'(move_ack), 0);
        if (tick_dec) tick = 1'b1;
        step();
        tick = 1'b0;
        move_req = 1'b0;

        exp_bump = 0;
        if (blk) exp_bump = 1;
        else if (g == 3'b000) begin mx = cx; my = cy; mwon = 1; end
        else if (w == 3'b000) exp_bump = 1;
        else begin mx = cx; my = cy; end
        if (exp_bump && mb < 255) mb++;
        if (tick_dec && mt > 0) mt--;

        check("ack", 32'(move_ack), 1);
        check("bump", 32'(bump), 32'(exp_bump));
        check_state("move");
        step();
        check("ack_pulse", 32'(move_ack), 0);
        check("bump_pulse", 32'(bump), 0);
        check("after_chkx", 32'(chk_x), 32'(mx));
    endtask

    // Frozen end state: ticks and requests are ignored until start.
    task automatic check_frozen(input string tag);
        tick = 1'b1; move_req = 1'b1; dir = 2'($urandom);
        repeat (6) begin
            step();
            check({tag, "_ack"}, 32'(move_ack), 0);
            check_state(tag);
        end
        tick = 1'b0; move_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; move_req = 1'b0; tick = 1'b0;
        dir = 2'b00; goal_flag = 3'b111; wall_flag = 3'b111;
        model_init();
        #12;
        check_state("reset");
        check("reset_ack", 32'(move_ack), 0);
        check("reset_bump", 32'(bump), 0);
        reset = 1'b0;
        step();

        // IDLE ignores requests and ticks.
        move_req = 1'b1; tick = 1'b1;
        repeat (6) begin
            step();
            check("idle_ack", 32'(move_ack), 0);
            check_state("idle");
        end
        move_req = 1'b0; tick = 1'b0;

        do_start();
        do_move(2'b10, 3'b111, 3'b111, 0);
        check("move_left_x", 32'(x_pos), 139);
        do_move(2'b11, 3'b111, 3'b000, 0);
        check("wall_bcnt", 32'(bump_count), 1);

        // start while a move is in flight has no effect.
        start = 1'b1;
        do_move(2'b01, 3'b101, 3'b011, 0);
        start = 1'b0;

        // Reset during WAIT aborts the move.
        dir = 2'b11; goal_flag = 3'b111; wall_flag = 3'b111; move_req = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        model_init();
        check_state("rst_wait");
        check("rst_wait_ack", 32'(move_ack), 0);
        #1 reset = 1'b0;
        repeat (6) begin
            step();
            check("rst_idle_ack", 32'(move_ack), 0);
            check_state("rst_idle");
        end
        move_req = 1'b0;
        do_start();

        // Random moves with random checker responses.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] g, w;
            g = ($urandom_range(0, 15) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            w = ($urandom_range(0, 3) == 0)  ? 3'b000 : 3'($urandom_range(1, 7));
            do_move(2'($urandom), g, w, 0);
            if (mwon) begin
                check_frozen("win_frozen");
                do_start();
            end
        end

        // Walk to the left edge at row 50, then bump off it.
        while (mx > 0)  do_move(2'b10, 3'b111, 3'b111, 0);
        while (my > 50) do_move(2'b00, 3'b111, 3'b111, 0);
        while (my < 50) do_move(2'b01, 3'b111, 3'b111, 0);
        do_move(2'b10, 3'b000, 3'b000, 0);
        check("edge_x", 32'(x_pos), 0);

        // Goal in the same clock the countdown hits zero still wins.
        do_ticks(mt - 1);
        check("time_one", 32'(time_left), 1);
        do_move(2'b01, 3'b000, 3'b000, 1);
        check("last_win", 32'(won), 1);
        check("last_lost", 32'(lost), 0);
        check("last_time", 32'(time_left), 0);
        check_frozen("win0_frozen");
        do_start();

        // Countdown expiry.
        do_ticks(99);
        check("expire_time", 32'(time_left), 0);
        check("expire_lost_early", 32'(lost), 0);
        step();
        mlost = 1;
        check_state("lose");
        check_frozen("lose_frozen");
        do_start();

        // Saturating bump counter.
        for (int i = 0; i < 258; i++) do_move(2'b00, 3'b111, 3'b000, 0);
        check("bcnt_sat", 32'(bump_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
